// File: rtl/uart_pkg.sv
// Shared defaults and FSM encoding for the UART transmit FIFO block.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_ADDR_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the result producer / serializer side and uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = NB_ADDR_DEFAULT
);

  logic               i_wr;
  logic [NB_DATA-1:0] i_data;
  logic               i_txDone;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_data;
  logic               o_full;
  logic               o_empty;
  logic [NB_ADDR:0]   o_count;
  logic               o_overflow;

  modport master (
    output i_wr, i_data, i_txDone,
    input  o_tx_start, o_data, o_full, o_empty, o_count, o_overflow
  );

  modport slave (
    input  i_wr, i_data, i_txDone,
    output o_tx_start, o_data, o_full, o_empty, o_count, o_overflow
  );

endinterface

// File: rtl/tx_fifo_mem.sv
// Register array for the transmit FIFO: synchronous write port, asynchronous read.
module tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
  end

  assign rdata = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that dispatches one start pulse per byte to uart_tx and waits for its done pulse.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_FLAG_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
  input  logic           clk,
  input  logic           i_rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [NB_ADDR:0] DEPTH = {1'b1, {NB_ADDR{1'b0}}};

  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic [NB_DATA-1:0] head;
  logic [NB_DATA-1:0] data_q;
  logic [NB_DATA-1:0] data_nxt;
  logic               start_q;
  logic               start_nxt;
  logic               full;
  logic               push;
  logic               pop;
  state_t             state;
  state_t             state_nxt;

  // Full uses the pre-edge count, so a write that coincides with a pop from a full FIFO is still dropped.
  assign full = (count == DEPTH);
  assign push = bus.i_wr & ~full;
  assign pop  = (state == ST_WAIT_DONE) & bus.i_txDone;

  tx_fifo_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wdata   (bus.i_data),
    .rd_addr (rd_ptr),
    .rdata   (head)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head byte is only popped on its done pulse, so count includes the byte in flight.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    data_nxt  = data_q;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          data_nxt  = head;
          start_nxt = 1'b1;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.i_txDone) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      data_q  <= data_nxt;
    end
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                ovf_q <= 1'b0;
    else if (bus.i_wr && full)   ovf_q <= 1'b1;
  end

  assign bus.o_overflow = ovf_q;
`else
  assign bus.o_overflow = 1'b0;
`endif

  assign bus.o_tx_start = start_q;
  assign bus.o_data     = data_q;
  assign bus.o_count    = count;
  assign bus.o_full     = full;
  assign bus.o_empty    = (count == '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences, random traffic vs a queue model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;

  uart_tx_fifo_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  uart_tx_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: queue of stored bytes (head is the one in flight while sending).
  logic [7:0] mq[$];
  logic [7:0] accepted[$];
  logic [7:0] sent[$];
  bit         sending;
  bit         m_start;
  bit         m_ovf;
  logic [7:0] m_data;
  bit         pending;

  typedef struct {
    bit         wr;
    logic [7:0] data;
    bit         done;
    int         reps;
    bit         e_start;
    logic [7:0] e_data;
    int         e_count;
    bit         e_empty;
    bit         e_full;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    accepted.delete();
    sent.delete();
    sending = 1'b0;
    m_start = 1'b0;
    m_ovf   = 1'b0;
    m_data  = 8'h00;
    pending = 1'b0;
  endtask

  task automatic model_step(bit wr, logic [7:0] d, bit done);
    int  pre;
    bit  launch;
    pre    = mq.size();
    launch = !sending && (pre > 0);
    m_start = launch;
    if (launch) m_data = mq[0];
    if (sending && done) begin
      void'(mq.pop_front());
      sending = 1'b0;
    end
    if (launch) sending = 1'b1;
    if (wr) begin
      if (pre < DEPTH) begin
        mq.push_back(d);
        accepted.push_back(d);
      end else if (OVF_EN) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("start", bus.o_tx_start, m_start);
    chk("data",  bus.o_data,     m_data);
    chk("count", bus.o_count,    mq.size());
    chk("empty", bus.o_empty,    mq.size() == 0);
    chk("full",  bus.o_full,     mq.size() == DEPTH);
    chk("ovf",   bus.o_overflow, m_ovf);
  endtask

  task automatic step(bit wr, logic [7:0] d, bit done, bit mchk);
    bus.i_wr     = wr;
    bus.i_data   = d;
    bus.i_txDone = done;
    if (done) pending = 1'b0;
    @(posedge clk);
    model_step(wr, d, done);
    @(negedge clk);
    bus.i_wr     = 1'b0;
    bus.i_txDone = 1'b0;
    if (mchk) check_model();
    if (bus.o_tx_start === 1'b1) begin
      sent.push_back(bus.o_data);
      pending = 1'b1;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = pending;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      ok = pending;
    end
    if (!ok) chk("start_timeout", pending, 1);
  endtask

  task automatic drain(int n, int dly);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_start(ok);
      if (!ok) return;
      repeat (dly - 1) step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end
  endtask

  task automatic check_order(string tag);
    chk({tag, "_len"}, sent.size(), accepted.size());
    for (int i = 0; i < sent.size() && i < accepted.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), sent[i], accepted[i]);
    sent.delete();
    accepted.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.i_wr = 1'b0;
    bus.i_data = 8'h00;
    bus.i_txDone = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1,  1'b0, 8'h00, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1,  1'b1, 8'hA5, 1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 18, 1'b0, 8'hA5, 1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1,  1'b0, 8'hA5, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 3,  1'b0, 8'hA5, 0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", bus.o_tx_start, 0);
    chk("rst_data",  bus.o_data,     0);
    chk("rst_count", bus.o_count,    0);
    chk("rst_empty", bus.o_empty,    1);
    chk("rst_full",  bus.o_full,     0);
    chk("rst_ovf",   bus.o_overflow, 0);
    i_rst_n = 1'b1;

    // Single byte through the vector table
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        step(tbl[i].wr, tbl[i].data, tbl[i].done, 1'b0);
        chk($sformatf("vec%0d_start", i), bus.o_tx_start, tbl[i].e_start);
        chk($sformatf("vec%0d_data", i),  bus.o_data,     tbl[i].e_data);
        chk($sformatf("vec%0d_count", i), bus.o_count,    tbl[i].e_count);
        chk($sformatf("vec%0d_empty", i), bus.o_empty,    tbl[i].e_empty);
        chk($sformatf("vec%0d_full", i),  bus.o_full,     tbl[i].e_full);
      end
    end
    check_order("single");

    // Burst of three, each answered 10 cycles after its start
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    drain(3, 10);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("burst_n", sent.size(), 3);
    if (sent.size() == 3) chk("burst_last", sent[2], 8'h03);
    check_order("burst");

    // Fill past capacity with the serializer stalled
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1);
      if (i == DEPTH - 1) chk("full_after_16", bus.o_full, 1);
    end
    chk("ovf_after_17", bus.o_overflow, OVF_EN);
    chk("count_after_17", bus.o_count, DEPTH);
    drain(DEPTH, 3);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_drain_n", sent.size(), DEPTH);
    check_order("full");

    // Wrap-around in batches of five
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + b * 5 + i), 1'b0, 1'b1);
      drain(5, $urandom_range(1, 4));
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_order("wrap");

    // Push coinciding with a pop at count 3
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("simul_count", bus.o_count, 3);
    drain(3, 2);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    if (sent.size() > 0) chk("simul_last", sent[sent.size() - 1], 8'h77);
    check_order("simul");

    // Reset in the middle of a transfer
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
    wait_start(ok);
    chk("pre_rst_count", bus.o_count, 4);
    i_rst_n = 1'b0;
    #1;
    chk("arst_start", bus.o_tx_start, 0);
    chk("arst_data",  bus.o_data,     0);
    chk("arst_count", bus.o_count,    0);
    chk("arst_empty", bus.o_empty,    1);
    chk("arst_ovf",   bus.o_overflow, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_starts", sent.size(), 0);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    drain(1, 2);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_order("postrst");

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bit wr;
      bit done;
      wr   = ($urandom_range(0, 99) < 55);
      done = pending ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 3);
      step(wr, 8'($urandom), done, 1'b1);
    end
    for (int g = 0; g < 40 && mq.size() > 0; g++) drain(1, $urandom_range(1, 5));
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_order("random");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
